rand_ctrl: RTL and testbench

Sequencing controller that sits directly upstream of the LFSR random datapath. On a `start` request it drives the datapath's `load` / `xor_en` / `shift_en` strobes and its 6-bit seed input for a fixed number of steps. It also consumes the datapath's registered 2-bit `result`, counting how many sampled results equal a programmable target. At the end of a run it reports completion with a one-cycle `done` pulse and a stable hit count.

---
 rtl/rand_pkg.sv | 19 +
 rtl/rand_hit_counter.sv | 38 +++
 rtl/rand_ctrl.sv | 124 ++++++++++++
 tb/tb_rand_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rand_pkg.sv
// Shared types and constants for the rand_ctrl sequencing slice.
// Configuration macro RAND_CTRL_ZERO_GUARD_EN (used in rand_ctrl) selects the zero-seed guard.
package rand_pkg;

    localparam int RAND_W = 6;
    localparam int RES_W  = 2;

    // Substituted for an all-zero seed so the LFSR cannot lock up.
    localparam logic [RAND_W-1:0] GUARD_SEED = 6'b000001;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/rand_hit_counter.sv
// Samples the datapath result one edge after each step strobe and counts
// matches against the captured target, saturating at the counter maximum.
module rand_hit_counter
    import rand_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             step_en,
    input  logic [RES_W-1:0] target,
    input  logic [RES_W-1:0] result_in,
    output logic [CNT_W-1:0] hit_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic samp;

    // result_in is registered in the datapath, so it reflects the value before
    // each step one edge after that step's strobe; samp carries that delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp      <= 1'b0;
            hit_count <= '0;
        end else begin
            samp <= step_en;
            if (clear) begin
                hit_count <= '0;
            end else if (samp && (result_in == target) && (hit_count != CNT_MAX)) begin
                hit_count <= hit_count + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/rand_ctrl.sv
// Run sequencer for the LFSR datapath: LOAD, STEPS step cycles, DRAIN, DONE.
// Define RAND_CTRL_ZERO_GUARD_EN to replace an all-zero seed with GUARD_SEED.
module rand_ctrl
    import rand_pkg::*;
#(
    parameter int STEPS = 16,
    parameter int CNT_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [RAND_W-1:0] seed,
    input  logic [RES_W-1:0]  target,
    input  logic [RES_W-1:0]  result_in,
    output logic [RAND_W-1:0] seed_out,
    output logic              load,
    output logic              xor_en,
    output logic              shift_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  hit_count,
    output state_t            state_dbg
);

    // Handshake: start is a level request accepted only on an edge seen in IDLE
    // (ignored while busy); each accepted request yields exactly one done pulse,
    // with hit_count final in that same cycle and held until the next accept.

    localparam int STEP_W = $clog2(STEPS + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

    state_t              state;
    logic [STEP_W-1:0]   step_cnt;
    logic                mode_q;
    logic [RES_W-1:0]    target_q;
    logic [RAND_W-1:0]   seed_cap;
    logic                accept;

`ifdef RAND_CTRL_ZERO_GUARD_EN
    assign seed_cap = (seed == '0) ? GUARD_SEED : seed;
`else
    assign seed_cap = seed;
`endif

    assign accept    = (state == ST_IDLE) && start;
    assign state_dbg = state;

    // Strobes are registered alongside the next state, so each output is a
    // pure function of the state register the cycle it is visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            step_cnt <= '0;
            mode_q   <= 1'b0;
            target_q <= '0;
            seed_out <= '0;
            load     <= 1'b0;
            xor_en   <= 1'b0;
            shift_en <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_q   <= mode;
                        target_q <= target;
                        seed_out <= seed_cap;
                        step_cnt <= '0;
                        load     <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    load     <= 1'b0;
                    xor_en   <= ~mode_q;
                    shift_en <= mode_q;
                    state    <= ST_RUN;
                end
                ST_RUN: begin
                    step_cnt <= step_cnt + STEP_ONE;
                    if (step_cnt == STEP_LAST) begin
                        xor_en   <= 1'b0;
                        shift_en <= 1'b0;
                        state    <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    done  <= 1'b1;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    load     <= 1'b0;
                    xor_en   <= 1'b0;
                    shift_en <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    rand_hit_counter #(
        .CNT_W (CNT_W)
    ) u_hit (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (accept),
        .step_en   (xor_en | shift_en),
        .target    (target_q),
        .result_in (result_in),
        .hit_count (hit_count)
    );

endmodule

// File: tb/tb_rand_ctrl.sv
// Bench for rand_ctrl: a datapath stand-in, an offset-based run model checked
// every cycle, and directed runs with hand-computed hit counts and latencies.
module tb_rand_ctrl;
    import rand_pkg::*;

    localparam int STEPS   = 4;
    localparam int S_STEPS = 40;
    localparam int CNT_W   = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // main instance (STEPS=4)
    logic              start, mode;
    logic [RAND_W-1:0] seed;
    logic [RES_W-1:0]  target;
    logic [RES_W-1:0]  result_in;
    logic [RAND_W-1:0] seed_out;
    logic              load, xor_en, shift_en, busy, done;
    logic [CNT_W-1:0]  hit_count;
    state_t            state_dbg;

    // saturation instance (STEPS=40)
    logic              s_start, s_mode;
    logic [RAND_W-1:0] s_seed;
    logic [RES_W-1:0]  s_target;
    logic [RES_W-1:0]  s_result_in;
    logic [RAND_W-1:0] s_seed_out;
    logic              s_load, s_xor_en, s_shift_en, s_busy, s_done;
    logic [CNT_W-1:0]  s_hit_count;
    state_t            s_state_dbg;

    int n_vec = 0;
    int n_err = 0;

    rand_ctrl #(.STEPS(STEPS), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .seed(seed),
        .target(target), .result_in(result_in), .seed_out(seed_out),
        .load(load), .xor_en(xor_en), .shift_en(shift_en), .busy(busy),
        .done(done), .hit_count(hit_count), .state_dbg(state_dbg)
    );

    rand_ctrl #(.STEPS(S_STEPS), .CNT_W(CNT_W)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(s_start), .mode(s_mode), .seed(s_seed),
        .target(s_target), .result_in(s_result_in), .seed_out(s_seed_out),
        .load(s_load), .xor_en(s_xor_en), .shift_en(s_shift_en), .busy(s_busy),
        .done(s_done), .hit_count(s_hit_count), .state_dbg(s_state_dbg)
    );

    function automatic logic [5:0] lfsr_next(input logic [5:0] v);
        return {v[4:0], v[5] ^ v[4]};
    endfunction

    // datapath stand-ins: 6-bit register, registered top-two-bit result
    logic [5:0] dp_reg = '0, s_dp_reg = '0;
    logic [1:0] dp_res = '0, s_dp_res = '0;
    assign result_in   = dp_res;
    assign s_result_in = s_dp_res;

    always @(posedge clk) begin
        dp_res <= dp_reg[5:4];
        if (load)          dp_reg <= seed_out;
        else if (xor_en)   dp_reg <= lfsr_next(dp_reg);
        else if (shift_en) dp_reg <= {dp_reg[4:0], 1'b0};
        s_dp_res <= s_dp_reg[5:4];
        if (s_load)          s_dp_reg <= s_seed_out;
        else if (s_xor_en)   s_dp_reg <= lfsr_next(s_dp_reg);
        else if (s_shift_en) s_dp_reg <= {s_dp_reg[4:0], 1'b0};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic logic [5:0] exp_seed(input logic [5:0] s);
`ifdef RAND_CTRL_ZERO_GUARD_EN
        return (s == 6'd0) ? 6'd1 : s;
`else
        return s;
`endif
    endfunction

    // Hits of a whole run: sample the top bits before each step, seed first.
    function automatic int model_hits(input logic [5:0] s, input logic m,
                                      input logic [1:0] t, input int steps);
        int h = 0;
        logic [5:0] v = s;
        for (int i = 0; i < steps; i++) begin
            if (v[5:4] == t && h < (1 << CNT_W) - 1) h++;
            v = m ? {v[4:0], 1'b0} : lfsr_next(v);
        end
        return h;
    endfunction

    // Run model: m_k is the offset of the current cycle from the start edge.
    bit         m_active = 1'b0;
    int         m_k = 0;
    bit         m_mode = 1'b0;
    logic [5:0] m_seed = '0;
    int         m_hits = 0;
    int         m_last = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0; m_k = 0; m_mode = 1'b0;
            m_seed = '0; m_hits = 0; m_last = 0;
        end else if (m_active) begin
            m_k++;
            if (m_k > STEPS + 3) begin
                m_active = 1'b0;
                m_last   = m_hits;
            end
        end else if (start) begin
            m_active = 1'b1;
            m_k      = 1;
            m_mode   = mode;
            m_seed   = exp_seed(seed);
            m_hits   = model_hits(exp_seed(seed), mode, target, STEPS);
        end
    end

    always @(negedge clk) begin
        bit e_run;
        e_run = m_active && m_k >= 2 && m_k <= STEPS + 1;
        chk("load", 32'(load), 32'(m_active && m_k == 1));
        chk("xor_en", 32'(xor_en), 32'(e_run && !m_mode));
        chk("shift_en", 32'(shift_en), 32'(e_run && m_mode));
        chk("busy", 32'(busy), 32'(m_active));
        chk("done", 32'(done), 32'(m_active && m_k == STEPS + 3));
        chk("seed_out", 32'(seed_out), 32'(m_seed));
        if (!m_active)                chk("hit_idle", 32'(hit_count), 32'(m_last));
        else if (m_k == 1)            chk("hit_clear", 32'(hit_count), 32'd0);
        else if (m_k == STEPS + 3)    chk("hit_done", 32'(hit_count), 32'(m_hits));
    end

    // One run on the main instance; repulse>0 re-pulses start at that offset.
    task automatic run_main(input logic [5:0] sd, input logic md, input logic [1:0] tg,
                            input int exp_hits, input logic [5:0] exp_so,
                            input int exp_xor, input int exp_shift, input int repulse);
        int cyc, nx, ns;
        @(negedge clk);
        start = 1'b1; seed = sd; mode = md; target = tg;
        @(negedge clk);
        start = 1'b0;
        chk("load_cycle", 32'(load), 32'd1);
        chk("load_seed", 32'(seed_out), 32'(exp_so));
        cyc = 1; nx = 0; ns = 0;
        while (!done && cyc < 60) begin
            start = (cyc == repulse);
            @(negedge clk);
            cyc++;
            if (xor_en) nx++;
            if (shift_en) ns++;
        end
        start = 1'b0;
        chk("done_latency", 32'(cyc), 32'(STEPS + 3));
        chk("hit_literal", 32'(hit_count), 32'(exp_hits));
        chk("xor_cycles", 32'(nx), 32'(exp_xor));
        chk("shift_cycles", 32'(ns), 32'(exp_shift));
        @(negedge clk);
    endtask

    initial begin
        int cyc, ns, nx;
        logic [5:0] zero_so;
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; seed = '0; target = '0;
        s_start = 1'b0; s_mode = 1'b0; s_seed = '0; s_target = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hit", 32'(hit_count), 32'd0);
        chk("rst_seed_out", 32'(seed_out), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        rst_n = 1'b1;

        // seed 100000: samples 10,00,00,00
        run_main(6'b100000, 1'b0, 2'b10, 1, 6'b100000, 4, 0, 0);
        run_main(6'b100000, 1'b0, 2'b00, 3, 6'b100000, 4, 0, 0);
        // shift 110000: samples 11,10,00,00
        run_main(6'b110000, 1'b1, 2'b00, 2, 6'b110000, 0, 4, 0);
        // start pulsed again while busy is ignored
        run_main(6'b100000, 1'b0, 2'b00, 3, 6'b100000, 4, 0, 3);

        // start held high: back-to-back runs separated by one IDLE cycle
        @(negedge clk);
        start = 1'b1; seed = 6'b110000; mode = 1'b1; target = 2'b11;
        cyc = 0;
        while (!done && cyc < 60) begin @(negedge clk); cyc++; end
        chk("held_first_done", 32'(cyc), 32'(STEPS + 3));
        @(negedge clk);
        cyc = 1;
        while (!done && cyc < 60) begin @(negedge clk); cyc++; end
        chk("held_gap", 32'(cyc), 32'(STEPS + 4));
        chk("held_hit", 32'(hit_count), 32'd1);
        start = 1'b0;
        repeat (2) @(negedge clk);

        // reset during RUN
        start = 1'b1; seed = 6'b100000; mode = 1'b0; target = 2'b00;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_xor", 32'(xor_en), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_seed", 32'(seed_out), 32'd0);
        chk("mid_rst_hit", 32'(hit_count), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run_main(6'b100000, 1'b0, 2'b10, 1, 6'b100000, 4, 0, 0);

        // zero seed: all samples 00 with or without the guard
`ifdef RAND_CTRL_ZERO_GUARD_EN
        zero_so = 6'b000001;
`else
        zero_so = 6'b000000;
`endif
        run_main(6'b000000, 1'b0, 2'b00, 4, zero_so, 4, 0, 0);

        // saturation: 40 shift steps from seed 0, at least 38 samples of 00
        s_start = 1'b1; s_seed = 6'b000000; s_mode = 1'b1; s_target = 2'b00;
        @(negedge clk);
        s_start = 1'b0;
        chk("sat_load", 32'(s_load), 32'd1);
        chk("sat_seed", 32'(s_seed_out), 32'(zero_so));
        cyc = 1; ns = 0; nx = 0;
        while (!s_done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (s_shift_en) ns++;
            if (s_xor_en) nx++;
            if (!s_busy) begin
                chk("sat_busy", 32'(s_busy), 32'd1);
                cyc = 100;
            end
        end
        chk("sat_latency", 32'(cyc), 32'(S_STEPS + 3));
        chk("sat_hit", 32'(s_hit_count), 32'd31);
        chk("sat_shift_cycles", 32'(ns), 32'(S_STEPS));
        chk("sat_xor_cycles", 32'(nx), 32'd0);
        repeat (3) @(negedge clk);
        chk("sat_hold", 32'(s_hit_count), 32'd31);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
